axil_param_regs: RTL and testbench

//   Parametrised AXI4-Lite slave register bank for the HPU control plane. Holds the CTRL word
//   (run/gen), NUM_REGS-1 writable 32-bit config registers (addr_i, addr_j, random_num, control, ...)
//   and NUM_STATUS read-only status words. Adds byte strobes, out-of-range SLVERR and

---
 rtl/axil_param_regs.sv | 120 ++++++++++++
 tb/tb_axil_param_regs.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/axil_param_regs.sv
// axil_param_regs: AXI4-Lite register bank with CTRL run/gen, byte-strobed config words and RO status words
module axil_param_regs #(
  parameter int ADDR_W = 12,
  parameter int NUM_REGS = 8,
  parameter int NUM_STATUS = 2,
  parameter logic [31:0] CFG_RST = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic                     run,
  output logic                     gen,
  input  logic                     gen_done,
  input  logic                     run_done,
  output logic [NUM_REGS*32-1:0]   cfg_regs,
  input  logic [NUM_STATUS*32-1:0] status_in
);
  typedef enum logic [2:0] {IDLE, AW, W, AWW, AR1, AR2} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d, waddr;
  logic [31:0] wdata_q, wdata_d, wd, rdata_q, rdata_d, widx, ridx;
  logic [3:0] wstrb_q, wstrb_d, ws;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] cfg_q [NUM_REGS];
  logic [31:0] cfg_d [NUM_REGS];
  logic commit;
  assign S_AXI_AWREADY = state_q == IDLE || state_q == W;
  assign S_AXI_WREADY = state_q == IDLE || state_q == AW;
  // the read is held off while a write is being offered in IDLE, since the write wins
  assign S_AXI_ARREADY = state_q == IDLE && !S_AXI_AWVALID && !S_AXI_WVALID;
  assign S_AXI_BVALID = state_q == AWW;
  assign S_AXI_RVALID = state_q == AR2;
  assign S_AXI_BRESP = bresp_q;
  assign S_AXI_RRESP = rresp_q;
  assign S_AXI_RDATA = rdata_q;
  assign gen = cfg_q[0][0];
  assign run = cfg_q[0][1];
  always_comb begin
    cfg_regs = '0;
    for (int k = 0; k < NUM_REGS; k++) cfg_regs[32*k+:32] = cfg_q[k];
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = (S_AXI_AWVALID && S_AXI_WVALID) ? AWW : S_AXI_AWVALID ? AW :
                      S_AXI_WVALID ? W : S_AXI_ARVALID ? AR1 : IDLE;
      AW:   state_d = S_AXI_WVALID ? AWW : AW;
      W:    state_d = S_AXI_AWVALID ? AWW : W;
      AWW:  state_d = S_AXI_BREADY ? IDLE : AWW;
      AR1:  state_d = AR2;
      AR2:  state_d = S_AXI_RREADY ? IDLE : AR2;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    awaddr_d = (S_AXI_AWVALID && S_AXI_AWREADY) ? S_AXI_AWADDR : awaddr_q;
    wdata_d = (S_AXI_WVALID && S_AXI_WREADY) ? S_AXI_WDATA : wdata_q;
    wstrb_d = (S_AXI_WVALID && S_AXI_WREADY) ? S_AXI_WSTRB : wstrb_q;
    araddr_d = (S_AXI_ARVALID && S_AXI_ARREADY) ? S_AXI_ARADDR : araddr_q;
    waddr = state_q == AW ? awaddr_q : S_AXI_AWADDR;
    wd = state_q == W ? wdata_q : S_AXI_WDATA;
    ws = state_q == W ? wstrb_q : S_AXI_WSTRB;
    widx = 32'(waddr) >> 2;
    ridx = 32'(araddr_q) >> 2;
    commit = state_d == AWW && state_q != AWW;
    bresp_d = commit ? ((widx < NUM_REGS) ? 2'b00 : 2'b10) : bresp_q;
    cfg_d = cfg_q;
    cfg_d[0] = {30'b0, (commit && widx == 0 && ws[0]) ? wd[1:0] : cfg_q[0][1:0] & ~{run_done, gen_done}};
    for (int k = 1; k < NUM_REGS; k++)
      for (int j = 0; j < 4; j++)
        if (commit && widx == k && ws[j]) cfg_d[k][8*j+:8] = wd[8*j+:8];
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (state_q == AR1) begin
      rdata_d = '0;
      rresp_d = 2'b10;
      for (int k = 0; k < NUM_REGS; k++)
        if (ridx == k) {rdata_d, rresp_d} = {cfg_q[k], 2'b00};
      for (int s = 0; s < NUM_STATUS; s++)
        if (ridx == NUM_REGS + s) {rdata_d, rresp_d} = {status_in[32*s+:32], 2'b00};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bresp_q <= 2'b00;
      rresp_q <= 2'b00;
      rdata_q <= '0;
      for (int k = 0; k < NUM_REGS; k++) cfg_q[k] <= k == 0 ? '0 : CFG_RST;
    end else begin
      state_q <= state_d;
      bresp_q <= bresp_d;
      rresp_q <= rresp_d;
      rdata_q <= rdata_d;
      cfg_q <= cfg_d;
    end
  end
  always_ff @(posedge clk) begin
    awaddr_q <= awaddr_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
    araddr_q <= araddr_d;
  end
endmodule

// File: tb/tb_axil_param_regs.sv
// tb_axil_param_regs: directed checks of writes, strobes, auto-clear, reads, SLVERR and reset
module tb_axil_param_regs;
  logic clk = 0, rst = 1;
  logic [11:0] S_AXI_AWADDR = 0, S_AXI_ARADDR = 0;
  logic S_AXI_AWVALID = 0, S_AXI_AWREADY, S_AXI_WVALID = 0, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA = 0, S_AXI_RDATA;
  logic [3:0] S_AXI_WSTRB = 0;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
  logic S_AXI_BVALID, S_AXI_BREADY = 0, S_AXI_ARVALID = 0, S_AXI_ARREADY;
  logic S_AXI_RVALID, S_AXI_RREADY = 0;
  logic run, gen, gen_done = 0, run_done = 0;
  logic [255:0] cfg_regs;
  logic [63:0] status_in = 0;
  int npass = 0, ntot = 0;
  always #5 clk = ~clk;
  axil_param_regs dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .run(run), .gen(gen),
    .gen_done(gen_done), .run_done(run_done), .cfg_regs(cfg_regs), .status_in(status_in)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic wr(input string tag, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic gd, input logic rd_, input logic [1:0] er);
    {S_AXI_AWADDR, S_AXI_WDATA, S_AXI_WSTRB} = {a, d, s};
    {S_AXI_AWVALID, S_AXI_WVALID, gen_done, run_done} = {2'b11, gd, rd_};
    tick();
    {S_AXI_AWVALID, S_AXI_WVALID, gen_done, run_done} = 4'b0;
    check({tag, "_bvalid"}, S_AXI_BVALID, 1);
    check({tag, "_bresp"}, S_AXI_BRESP, er);
    S_AXI_BREADY = 1;
    tick();
    S_AXI_BREADY = 0;
  endtask
  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] ed, input logic [1:0] er,
                    input int hold);
    S_AXI_ARADDR = a;
    S_AXI_ARVALID = 1;
    check({tag, "_arready"}, S_AXI_ARREADY, 1);
    tick();
    S_AXI_ARVALID = 0;
    check({tag, "_rvalid_early"}, S_AXI_RVALID, 0);
    tick();
    check({tag, "_rvalid"}, S_AXI_RVALID, 1);
    check({tag, "_rdata"}, S_AXI_RDATA, ed);
    check({tag, "_rresp"}, S_AXI_RRESP, er);
    for (int i = 0; i < hold; i++) begin
      status_in = ~status_in;
      tick();
      check({tag, "_hold"}, {S_AXI_RVALID, S_AXI_RDATA[30:0]}, {1'b1, ed[30:0]});
    end
    S_AXI_RREADY = 1;
    tick();
    S_AXI_RREADY = 0;
    check({tag, "_rvalid_drop"}, S_AXI_RVALID, 0);
  endtask
  initial begin
    tick();
    tick();
    rst = 0;
    check("rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    check("rst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 0);
    check("rst_resp", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 0);
    check("rst_ctrl", {run, gen}, 0);
    check("rst_cfg", cfg_regs[63:0], 0);
    wr("t1", 12'h000, 32'h3, 4'hF, 0, 0, 2'b00);
    check("t1_rungen", {run, gen}, 2'b11);
    {S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID} = {32'hDEADBEEF, 4'b0101, 1'b1};
    tick();
    S_AXI_WVALID = 0;
    check("t2_wready_low", S_AXI_WREADY, 0);
    tick();
    tick();
    check("t2_no_commit", cfg_regs[63:32], 0);
    S_AXI_AWADDR = 12'h004;
    S_AXI_AWVALID = 1;
    tick();
    S_AXI_AWVALID = 0;
    check("t2_bvalid", S_AXI_BVALID, 1);
    check("t2_word1", cfg_regs[63:32], 32'h00AD00EF);
    check("t2_word2", cfg_regs[95:64], 0);
    S_AXI_BREADY = 1;
    tick();
    S_AXI_BREADY = 0;
    wr("t3a", 12'h000, 32'h1, 4'hF, 1, 0, 2'b00);
    check("t3_commit_wins", {run, gen}, 2'b01);
    gen_done = 1;
    tick();
    gen_done = 0;
    check("t3_gen_clear", {run, gen}, 2'b00);
    wr("t3b", 12'h000, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b00);
    check("t3_ctrl_bits", cfg_regs[31:0], 32'h3);
    wr("t3c", 12'h000, 32'h0, 4'hE, 0, 0, 2'b00);
    check("t3_strb0_off", {run, gen}, 2'b11);
    run_done = 1;
    tick();
    run_done = 0;
    check("t3_run_clear", {run, gen}, 2'b01);
    status_in = {32'hCAFEF00D, 32'h12345678};
    rd("t4", 12'h020, 32'h12345678, 2'b00, 5);
    status_in = {32'hCAFEF00D, 32'h12345678};
    rd("t4_st1", 12'h024, 32'hCAFEF00D, 2'b00, 0);
    rd("t4_w1", 12'h004, 32'h00AD00EF, 2'b00, 0);
    rd("t4_ctrl", 12'h000, 32'h1, 2'b00, 0);
    wr("t4_w7", 12'h01C, 32'hA5A5_5A5A, 4'hF, 0, 0, 2'b00);
    rd("t4_r7", 12'h01C, 32'hA5A5_5A5A, 2'b00, 0);
    wr("t5", 12'h3FC, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b10);
    check("t5_cfg_lo", cfg_regs[63:0], 64'h00AD00EF_00000001);
    check("t5_cfg_w7", cfg_regs[255:224], 32'hA5A5_5A5A);
    wr("t5_w8", 12'h020, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b10);
    check("t5_cfg_mid", cfg_regs[223:64], 0);
    rd("t5_r", 12'h3FC, 32'h0, 2'b10, 0);
    rd("t5_r10", 12'h028, 32'h0, 2'b10, 0);
    wr("t6w", 12'h000, 32'h3, 4'h1, 0, 0, 2'b00);
    S_AXI_ARADDR = 12'h004;
    S_AXI_ARVALID = 1;
    tick();
    S_AXI_ARVALID = 0;
    tick();
    check("t6_rvalid", S_AXI_RVALID, 1);
    rst = 1;
    tick();
    rst = 0;
    check("t6_rvalid_drop", S_AXI_RVALID, 0);
    check("t6_arready", S_AXI_ARREADY, 1);
    check("t6_rungen", {run, gen}, 0);
    check("t6_cfg", cfg_regs[63:32], 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
